btn_event_decoder: RTL and testbench



---
 rtl/btn_event_decoder.sv | 161 ++++++++++++++++
 tb/tb_btn_event_decoder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/btn_event_decoder.sv
// Button event decoder: press/short/long/repeat/release pulses from a filtered level.
// Optional auto-repeat while long-held is enabled by defining BTN_REPEAT_EN.
module btn_event_decoder #(
    parameter int LONG_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press_p,
    output logic short_p,
    output logic long_p,
    output logic repeat_p,
    output logic release_p,
    output logic held
);

    localparam int CW = $clog2(LONG_CYCLES + 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync1_q, btn_s_q;
    logic          press_q, press_d;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          release_q, release_d;
    logic          held_q, held_d;

`ifdef BTN_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    localparam logic [RW-1:0] RCNT_ONE = RW'(1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          repeat_q, repeat_d;
`endif

    // btn_n is asynchronous to clk; sync FFs reset to "not pressed"
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            sync1_q <= ~btn_n;
            btn_s_q <= sync1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        release_d = 1'b0;
`ifdef BTN_REPEAT_EN
        rcnt_d    = rcnt_q;
        repeat_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = PRESSED;
                    cnt_d   = CNT_ONE;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                // release is checked first so it always beats the threshold
                if (!btn_s_q) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    short_d   = 1'b1;
                    release_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
`ifdef BTN_REPEAT_EN
                    rcnt_d  = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LONG: begin
                if (!btn_s_q) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
`ifdef BTN_REPEAT_EN
                    if (rcnt_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        rcnt_d   = '0;
                    end else begin
                        rcnt_d = rcnt_q + RCNT_ONE;
                    end
`else
                    state_d = LONG;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == PRESSED) || (state_d == LONG);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            short_q   <= short_d;
            long_q    <= long_d;
            release_q <= release_d;
            held_q    <= held_d;
        end
    end

`ifdef BTN_REPEAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt_q   <= '0;
            repeat_q <= 1'b0;
        end else begin
            rcnt_q   <= rcnt_d;
            repeat_q <= repeat_d;
        end
    end

    assign repeat_p = repeat_q;
`else
    assign repeat_p = 1'b0;
`endif

    assign press_p   = press_q;
    assign short_p   = short_q;
    assign long_p    = long_q;
    assign release_p = release_q;
    assign held      = held_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// Directed bench for btn_event_decoder (LONG_CYCLES=10, REPEAT_CYCLES=4).
// Event times are indexed from the first posedge after the stimulus starts.
module tb_btn_event_decoder;

    logic clk;
    logic rst;
    logic btn_n;
    logic press_p, short_p, long_p, repeat_p, release_p, held;

    int n_chk = 0;
    int n_err = 0;

    int n_press, n_short, n_long, n_rep, n_rel, n_bad;
    int t_press, t_short, t_long, t_rel;
    int t_rep[2];
    logic held_at_press;

    btn_event_decoder #(
        .LONG_CYCLES  (10),
        .REPEAT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_n    (btn_n),
        .press_p  (press_p),
        .short_p  (short_p),
        .long_p   (long_p),
        .repeat_p (repeat_p),
        .release_p(release_p),
        .held     (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Call at a negedge; holds btn_n low for 'low' cycles out of 'total'.
    task automatic run_seq(input int low, input int total);
        n_press = 0; n_short = 0; n_long = 0; n_rep = 0; n_rel = 0; n_bad = 0;
        t_press = -1; t_short = -1; t_long = -1; t_rel = -1;
        t_rep[0] = -1; t_rep[1] = -1;
        held_at_press = 1'b0;
        for (int i = 0; i < total; i++) begin
            btn_n = (i < low) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            if (press_p) begin
                n_press++; t_press = i; held_at_press = held;
            end
            if (short_p) begin
                n_short++; t_short = i;
            end
            if (long_p) begin
                n_long++; t_long = i;
            end
            if (release_p) begin
                n_rel++; t_rel = i;
            end
            if (repeat_p) begin
                if (n_rep < 2) t_rep[n_rep] = i;
                n_rep++;
            end
            if (int'(press_p) + int'(long_p) + int'(repeat_p) > 1) n_bad++;
            if (short_p && !release_p) n_bad++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst   = 1'b0;
        btn_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outputs",
            int'({press_p, short_p, long_p, repeat_p, release_p, held}), 0);

        // 1/2: button already down when reset releases, then 5-cycle hold
        @(negedge clk);
        rst = 1'b1;
        run_seq(5, 12);
        chk("t1_press_n", n_press, 1);
        chk("t1_press_t", t_press, 2);
        chk("t1_held", int'(held_at_press), 1);
        chk("t1_short_t", t_short, 7);
        chk("t1_rel_t", t_rel, 7);
        chk("t1_long_n", n_long, 0);
        chk("t1_bad", n_bad, 0);

        // 2: fresh 5-cycle press from idle
        run_seq(5, 12);
        chk("t2_press_t", t_press, 2);
        chk("t2_short_n", n_short, 1);
        chk("t2_rel_n", n_rel, 1);
        chk("t2_short_t", t_short, 7);
        chk("t2_held_end", int'(held), 0);

        // 3: 9 cycles is still short, 10 cycles is long
        run_seq(9, 16);
        chk("t3a_short_t", t_short, 11);
        chk("t3a_rel_t", t_rel, 11);
        chk("t3a_long_n", n_long, 0);
        run_seq(10, 16);
        chk("t3b_long_t", t_long, 11);
        chk("t3b_rel_t", t_rel, 12);
        chk("t3b_short_n", n_short, 0);
        chk("t3b_bad", n_bad, 0);

        // 4: 20-cycle hold, repeats while long-held
        run_seq(20, 28);
        chk("t4_press_t", t_press, 2);
        chk("t4_long_t", t_long, 11);
        chk("t4_rel_t", t_rel, 22);
        chk("t4_short_n", n_short, 0);
`ifdef BTN_REPEAT_EN
        chk("t4_rep_n", n_rep, 2);
        chk("t4_rep0_t", t_rep[0], 15);
        chk("t4_rep1_t", t_rep[1], 19);
`else
        chk("t4_rep_n", n_rep, 0);
`endif
        chk("t4_bad", n_bad, 0);

        // 5: release lands exactly where the first repeat would fire
        run_seq(13, 20);
        chk("t5_long_t", t_long, 11);
        chk("t5_rel_t", t_rel, 15);
        chk("t5_rep_n", n_rep, 0);
        chk("t5_held_end", int'(held), 0);

        // 6: reset while long-held, button released during reset
        run_seq(14, 14);
        chk("t6_long_t", t_long, 11);
        chk("t6_held_pre", int'(held), 1);
        rst   = 1'b0;
        btn_n = 1'b1;
        #1;
        chk("t6_rst_outputs",
            int'({press_p, short_p, long_p, repeat_p, release_p, held}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run_seq(0, 8);
        chk("t6_rel_n", n_rel, 0);
        chk("t6_press_n", n_press, 0);
        chk("t6_short_n", n_short, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
